// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC register and instruction memory, and fills IF/ID.
// A stalled response is parked in a one-word buffer. A flush drains an outstanding request without disturbing its address.
module fetch_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_write_o,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [15:0] fetch_count_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   buf_q;
    logic              ack;
    logic              deliver;
    logic              capture;
    logic              bubble;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush takes priority over stall and start
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (flush_i) begin
                    state_d = imem_ack_i ? S_FETCH : S_DRAIN;
                end else if (imem_ack_i && stall_i) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush_i || !stall_i) state_d = S_FETCH;
            end
            S_DRAIN: begin
                if (!flush_i && imem_ack_i) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath controls
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = addr_q;
        pc_next_o   = flush_i ? branch_target_i : pc_i + PC_STEP;
        pc_write_o  = 1'b0;
        ack         = 1'b0;
        deliver     = 1'b0;
        capture     = 1'b0;
        bubble      = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc_i;
            end
            S_DRAIN: begin
                imem_req_o  = 1'b1;
            end
            default: begin
                imem_req_o  = 1'b0;
            end
        endcase
        ack     = imem_req_o & imem_ack_i;
        deliver = !flush_i && !stall_i &&
                  (((state_q == S_FETCH) && ack) || (state_q == S_HOLD));
        capture = !flush_i && stall_i && (state_q == S_FETCH) && ack;
        bubble  = !deliver && (flush_i || !stall_i);
        // Reset level gates the flush term so the PC register is never written in reset
        pc_write_o = rst_i & (flush_i | deliver);
    end

    // Address latch, stall buffer, IF/ID register and delivery counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q        <= '0;
            buf_q         <= '0;
            ifid_valid_o  <= 1'b0;
            ifid_pc_o     <= '0;
            ifid_instr_o  <= NOP_INSTR;
            fetch_count_o <= '0;
        end else begin
            if (state_q == S_FETCH) addr_q <= pc_i;
            if (capture) buf_q <= imem_data_i;
            if (deliver) begin
                ifid_valid_o  <= 1'b1;
                ifid_pc_o     <= pc_i;
                ifid_instr_o  <= (state_q == S_HOLD) ? buf_q : imem_data_i;
                fetch_count_o <= fetch_count_o + CNT_W'(1);
            end else if (bubble) begin
                ifid_valid_o  <= 1'b0;
                ifid_instr_o  <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a behavioural model.
// The bench also plays the PC register, loading pc_next_o whenever pc_write_o is high.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic [31:0] pc_next_o;
    logic        pc_write_o;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic [15:0] fetch_count_o;

    fetch_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .pc_i            (pc_i),
        .pc_next_o       (pc_next_o),
        .pc_write_o      (pc_write_o),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_instr_o    (ifid_instr_o),
        .fetch_count_o   (fetch_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: running / parked-word / draining flags plus the visible registers
    bit          m_run, m_hold, m_drain, m_valid;
    logic [31:0] m_buf, m_addr, m_pc_id, m_instr, pc_reg;
    logic [15:0] m_cnt;
    bit          e_req, e_pw;
    logic [31:0] e_addr, e_next;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_hold = 0; m_drain = 0; m_valid = 0;
        m_buf = '0; m_addr = '0; m_pc_id = '0; m_instr = NOP; m_cnt = '0;
        pc_reg = '0;
    endtask

    task automatic set_in(input bit st, input bit sl, input bit fl, input logic [31:0] tgt,
                          input bit ak, input logic [31:0] dat);
        start_i = st; stall_i = sl; flush_i = fl; branch_target_i = tgt;
        imem_ack_i = ak; imem_data_i = dat; pc_i = pc_reg;
    endtask

    // Combinational outputs for the current inputs
    task automatic pre();
        bit fetching, ack_eff;
        #1;
        fetching = m_run && !m_hold && !m_drain;
        e_req    = fetching || m_drain;
        e_addr   = fetching ? pc_reg : m_addr;
        e_next   = flush_i ? branch_target_i : pc_reg + 32'd4;
        ack_eff  = e_req && imem_ack_i;
        e_pw     = flush_i || (fetching && ack_eff && !stall_i) || (m_hold && !stall_i);
        chk("pc_write", 32'(pc_write_o), 32'(e_pw));
        chk("imem_req", 32'(imem_req_o), 32'(e_req));
        chk("pc_next", pc_next_o, e_next);
        if (e_req) chk("imem_addr", imem_addr_o, e_addr);
    endtask

    // Clock edge: advance the model, then compare the registered outputs
    task automatic post();
        bit fetching, ack_eff, dl;
        logic [31:0] word;
        @(posedge clk_i);
        fetching = m_run && !m_hold && !m_drain;
        ack_eff  = (fetching || m_drain) && imem_ack_i;
        dl = 0; word = '0;
        if (!flush_i && !stall_i) begin
            if (fetching && ack_eff) begin dl = 1; word = imem_data_i; end
            else if (m_hold)         begin dl = 1; word = m_buf; end
        end
        if (fetching) m_addr = pc_reg;
        if (dl) begin
            m_valid = 1; m_pc_id = pc_reg; m_instr = word; m_cnt = m_cnt + 16'd1;
        end else if (flush_i || !stall_i) begin
            m_valid = 0; m_instr = NOP;
        end
        if (!m_run) begin
            if (start_i && !flush_i) m_run = 1;
        end else if (fetching) begin
            if (flush_i) begin
                if (!ack_eff) m_drain = 1;
            end else if (ack_eff && stall_i) begin
                m_hold = 1; m_buf = imem_data_i;
            end
        end else if (m_hold) begin
            if (flush_i || !stall_i) m_hold = 0;
        end else begin
            if (!flush_i && ack_eff) m_drain = 0;
        end
        if (e_pw) pc_reg = e_next;
        @(negedge clk_i);
        chk("ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
        chk("ifid_pc", ifid_pc_o, m_pc_id);
        chk("ifid_instr", ifid_instr_o, m_instr);
        chk("fetch_count", 32'(fetch_count_o), 32'(m_cnt));
    endtask

    task automatic cyc(input bit st, input bit sl, input bit fl, input logic [31:0] tgt,
                       input bit ak, input logic [31:0] dat);
        set_in(st, sl, fl, tgt, ak, dat);
        pre();
        post();
    endtask

    initial begin
        logic [31:0] r;
        rst_i = 1'b0;
        model_reset();
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", 32'(ifid_valid_o), 32'h0);
        chk("rst_instr", ifid_instr_o, NOP);
        chk("rst_count", 32'(fetch_count_o), 32'h0);
        chk("rst_req", 32'(imem_req_o), 32'h0);
        rst_i = 1'b1;

        // Back-to-back acks from PC 0
        cyc(1, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 32'h0, 1, 32'hA + 32'(i));
            pre();
            chk("s1_pw", 32'(pc_write_o), 32'h1);
            post();
            chk("s1_pc", ifid_pc_o, 32'(4 * i));
            chk("s1_instr", ifid_instr_o, 32'hA + 32'(i));
        end
        chk("s1_count", 32'(fetch_count_o), 32'd3);

        // Ack under stall parks the word in HOLD
        cyc(0, 0, 0, 32'h0, 1, 32'hD);
        set_in(0, 1, 0, 32'h0, 1, 32'h1234);
        pre();
        chk("s2_addr", imem_addr_o, 32'h10);
        chk("s2_pw", 32'(pc_write_o), 32'h0);
        post();
        chk("s2_hold_pc", ifid_pc_o, 32'hC);
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 0, 32'h0, 0, 32'h0);
            pre();
            chk("s2_hold_pw", 32'(pc_write_o), 32'h0);
            post();
        end
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        pre();
        chk("s2_next", pc_next_o, 32'h14);
        chk("s2_rel_pw", 32'(pc_write_o), 32'h1);
        post();
        chk("s2_valid", 32'(ifid_valid_o), 32'h1);
        chk("s2_pc", ifid_pc_o, 32'h10);
        chk("s2_instr", ifid_instr_o, 32'h1234);

        // Flush while a request at 0x20 is outstanding
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'h0, 1, 32'(i));
        cyc(0, 0, 0, 32'h0, 0, 32'h0);
        set_in(0, 0, 1, 32'h80, 0, 32'h0);
        pre();
        chk("s3_addr", imem_addr_o, 32'h20);
        post();
        chk("s3_bubble_v", 32'(ifid_valid_o), 32'h0);
        chk("s3_bubble_i", ifid_instr_o, NOP);
        set_in(0, 0, 0, 32'h0, 1, 32'hDEAD);
        pre();
        chk("s3_drain_req", 32'(imem_req_o), 32'h1);
        chk("s3_drain_addr", imem_addr_o, 32'h20);
        post();
        chk("s3_disc_v", 32'(ifid_valid_o), 32'h0);
        chk("s3_disc_i", ifid_instr_o, NOP);
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        pre();
        chk("s3_target", imem_addr_o, 32'h80);
        post();

        // Flush with stall while holding a parked word
        cyc(0, 1, 0, 32'h0, 1, 32'h55);
        set_in(0, 1, 1, 32'h100, 0, 32'h0);
        pre();
        chk("s4_pw", 32'(pc_write_o), 32'h1);
        post();
        chk("s4_bubble_v", 32'(ifid_valid_o), 32'h0);
        chk("s4_bubble_i", ifid_instr_o, NOP);
        set_in(0, 0, 0, 32'h0, 1, 32'h77);
        pre();
        chk("s4_addr", imem_addr_o, 32'h100);
        post();
        chk("s4_pc", ifid_pc_o, 32'h100);
        chk("s4_instr", ifid_instr_o, 32'h77);

        // Asynchronous reset in DRAIN
        cyc(0, 0, 1, 32'h200, 0, 32'h0);
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        pre();
        rst_i = 1'b0;
        #1;
        chk("s5_req", 32'(imem_req_o), 32'h0);
        chk("s5_valid", 32'(ifid_valid_o), 32'h0);
        chk("s5_pc", ifid_pc_o, 32'h0);
        chk("s5_instr", ifid_instr_o, NOP);
        chk("s5_count", 32'(fetch_count_o), 32'h0);
        flush_i = 1'b1;
        #1;
        chk("s5_pw", 32'(pc_write_o), 32'h0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        chk("s5_req_held", 32'(imem_req_o), 32'h0);
        flush_i = 1'b0;
        rst_i = 1'b1;
        cyc(0, 0, 0, 32'h0, 1, 32'h0);
        cyc(0, 0, 1, 32'h300, 0, 32'h0);

        // Counter wrap
        cyc(1, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 65535; i++) cyc(0, 0, 0, 32'h0, 1, $urandom);
        chk("s6_full", 32'(fetch_count_o), 32'hFFFF);
        cyc(0, 0, 0, 32'h0, 1, 32'h1);
        chk("s6_wrap", 32'(fetch_count_o), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0, r & 32'hFFFF_FFFC,
                $urandom_range(0, 1) == 1, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these ports, one clock domain:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  run enable from the top level
- pc_i  in  32  current PC from the PC register
- pc_next_o  out  32  next PC, wired to the PC register's pc_i
- pc_write_o  out  1  PC load enable, wired to the PC register's PCWrite_i
- stall_i  in  1  hazard-unit stall; 1 means ID cannot accept
- flush_i  in  1  taken branch/jump in ID
- branch_target_i  in  32  redirect target, valid when flush_i=1
- imem_req_o  out  1  instruction-memory request
- imem_addr_o  out  32  instruction-memory address
- imem_ack_i  in  1  request completes at an edge where imem_req_o=1 and imem_ack_i=1
- imem_data_i  in  32  instruction word, valid in the ack cycle
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_pc_o  out  32  PC of the IF/ID instruction
- ifid_instr_o  out  32  IF/ID instruction word
- fetch_count_o  out  16  count of instructions delivered to IF/ID

Function
REQ-002 The block SHALL implement FSM states IDLE, FETCH, HOLD and DRAIN.
REQ-003 IDLE SHALL move to FETCH at the first edge with start_i=1; start_i SHALL be ignored in every other state.
REQ-004 imem_req_o SHALL be 1 in FETCH and DRAIN and 0 in IDLE and HOLD.
REQ-005 In FETCH, imem_addr_o SHALL equal pc_i; in DRAIN, it SHALL equal addr_q, a register loaded with pc_i on every FETCH cycle.
REQ-006 pc_next_o SHALL be branch_target_i when flush_i=1, else pc_i+4 modulo 2^32.
REQ-007 pc_write_o SHALL be combinational and equal to 1 exactly when one of the following holds:
- flush_i=1 in any non-reset state
- FETCH, ack=1, stall_i=0
- HOLD, stall_i=0
REQ-008 In FETCH with ack=1, stall_i=0 and flush_i=0, the following SHALL load at that edge:
- IF/ID <= {valid=1, pc=pc_i, instr=imem_data_i}
- fetch_count_o increments
- state stays FETCH
- Back-to-back acks therefore deliver one instruction per cycle.
REQ-009 In FETCH with ack=1, stall_i=1 and flush_i=0, imem_data_i SHALL be captured into a one-word buffer, the state SHALL move to HOLD, and IF/ID SHALL hold.
REQ-010 In HOLD with stall_i=0 and flush_i=0, IF/ID SHALL load {1, pc_i, buffer}, fetch_count_o SHALL increment, and the state SHALL move to FETCH.
REQ-011 When stall_i=1 and flush_i=0, IF/ID SHALL hold its value in every state.
REQ-012 When stall_i=0, flush_i=0 and no instruction is delivered, IF/ID SHALL load a bubble: valid=0, instr=32'h00000013, pc unchanged.
REQ-013 flush_i=1 SHALL override stall_i as follows:
- IF/ID loads a bubble.
- FETCH with ack=1: data discarded, stay FETCH.
- FETCH with ack=0: move to DRAIN.
- HOLD: buffer discarded, move to FETCH.
- DRAIN: stay DRAIN.
- IDLE: stay IDLE.
REQ-014 DRAIN SHALL move to FETCH on ack, with the response discarded and IF/ID not loaded from it.
REQ-015 imem_addr_o SHALL stay stable while a request is outstanding, including across a flush.
REQ-016 fetch_count_o SHALL wrap from 16'hFFFF to 0.

Reset
REQ-017 When rst_i=0, the block SHALL immediately set the following regardless of clk_i, abandoning any outstanding request:
- state=IDLE
- imem_req_o=0
- addr_q=0
- buffer=0
- ifid_valid_o=0
- ifid_pc_o=0
- ifid_instr_o=32'h00000013
- fetch_count_o=0
REQ-018 While in reset or IDLE with flush_i=0, pc_write_o SHALL be 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release, start_i=1, pc_i=0, ack every cycle with data 0xA,0xB,0xC -> IF/ID pc 0,4,8 on consecutive cycles; pc_write_o=1 each cycle; fetch_count_o=3.
- Ack at pc_i=0x10 with stall_i=1 for 3 cycles, data 0x1234 -> state HOLD; pc_write_o=0; IF/ID unchanged; on stall release IF/ID={1,0x10,0x1234}; pc_next_o=0x14.
- flush_i=1 with target 0x80 while a FETCH request at 0x20 waits 2 cycles for ack -> DRAIN; imem_addr_o stays 0x20; response discarded; next request at 0x80; IF/ID valid=0 with NOP.
- flush_i=1 and stall_i=1 in HOLD -> bubble loaded; buffer dropped; pc_write_o=1; next fetch at target.
- rst_i low mid-request in DRAIN -> all REQ-017 values immediately; imem_req_o=0 before the next edge.
- Preload fetch_count_o to 16'hFFFF via 65535 deliveries, then one more delivery -> fetch_count_o=0.
